// File: rtl/mul_seq_n_if.sv
// mul_seq_n_if
// Bundles the start/done handshake, operands and results of the sequential
// multiplier so the execute stage and the unit share one connection.
//
// Signals (WIDTH = operand width):
//   start      request, taken only while ready=1
//   op[1:0]    00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   a, b       multiplicand (rs1) and multiplier (rs2)
//   kill       abort an in-flight operation (pipeline flush)
//   ready      unit can accept start this cycle
//   busy       operation in progress
//   done       one-cycle pulse, results valid
//   result_hi  upper WIDTH bits of the 2*WIDTH product
//   result_lo  lower WIDTH bits of the 2*WIDTH product
//
// master: the requester (execute stage or bench); slave: the multiplier.
interface mul_seq_n_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             kill;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    modport master (
        output start, op, a, b, kill,
        input  ready, busy, done, result_hi, result_lo
    );

    modport slave (
        input  start, op, a, b, kill,
        output ready, busy, done, result_hi, result_lo
    );
endinterface

// File: rtl/mul_seq_n.sv
// mul_seq_n
// Multi-cycle shift-add multiplier covering MUL, MULH, MULHSU and MULHU.
// Operands are converted to magnitudes on the start edge, BPC multiplier
// bits are retired per CALC cycle into a 2*WIDTH accumulator, and the sign
// is reapplied in a single FIX cycle. A new operation may be issued in the
// DONE cycle, so results can be produced back to back.
//
// Parameters:
//   WIDTH  operand width; the product is 2*WIDTH bits
//   BPC    multiplier bits retired per CALC cycle; must divide WIDTH
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high; aborts any operation and clears results
//   bus    mul_seq_n_if slave modport (start/op/a/b/kill in,
//          ready/busy/done/result_hi/result_lo out)
module mul_seq_n #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic       clk,
    input  logic       reset,
    mul_seq_n_if.slave bus
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // A BPC that does not divide WIDTH would leave multiplier bits unretired.
    generate
        if (BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_bpc
            $error("mul_seq_n: BPC must divide WIDTH");
        end
    endgenerate

    logic [1:0]       state;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    count;
    logic             neg;
    logic             done_q;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    step_sum;
    logic             idle_or_done;
    logic             take_start;

    // Operand magnitudes. The most negative value maps onto itself, which
    // reads correctly as 2^(WIDTH-1) once treated as unsigned.
    always_comb begin
        a_signed = (bus.op != 2'b11);
        b_signed = ~bus.op[1];
        a_neg    = a_signed & bus.a[WIDTH-1];
        b_neg    = b_signed & bus.b[WIDTH-1];
        a_mag    = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
        b_mag    = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
    end

    // One CALC step: add mcand shifted by each set bit in the low BPC bits
    // of the multiplier.
    always_comb begin
        step_sum = acc;
        for (int i = 0; i < BPC; i++) begin
            if (mplier[i]) begin
                step_sum = step_sum + (mcand << i);
            end
        end
    end

    // A kill arriving in the DONE cycle drops a simultaneous start; in IDLE
    // kill has nothing to abort, so the start goes ahead.
    always_comb begin
        idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
        take_start   = idle_or_done && bus.start &&
                       !((state == ST_DONE) && bus.kill);
    end

    // Control: state sequencing and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
            count  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (take_start) begin
                        state <= ST_CALC;
                        count <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (bus.kill) begin
                        state <= ST_IDLE;
                    end else begin
                        count <= count + CW'(1);
                        if (count == CW'(N - 1)) begin
                            state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (bus.kill) begin
                        state <= ST_IDLE;
                    end else begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Datapath: operand latch, accumulation and sign fix-up. Results only
    // change in a FIX cycle that is not being killed.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            if (take_start) begin
                mcand  <= {{WIDTH{1'b0}}, a_mag};
                mplier <= b_mag;
                acc    <= '0;
                neg    <= a_neg ^ b_neg;
            end else if (state == ST_CALC && !bus.kill) begin
                acc    <= step_sum;
                mcand  <= mcand << BPC;
                mplier <= mplier >> BPC;
            end else if (state == ST_FIX && !bus.kill) begin
                {res_hi, res_lo} <= neg ? (~acc + PW'(1)) : acc;
            end
        end
    end

    assign bus.ready     = idle_or_done;
    assign bus.busy      = (state == ST_CALC) || (state == ST_FIX);
    assign bus.done      = done_q;
    assign bus.result_hi = res_hi;
    assign bus.result_lo = res_lo;

endmodule

// File: tb/tb_mul_seq_n.sv
// tb_mul_seq_n
// Drives four multipliers (BPC = 1, 2, 4, 8; WIDTH = 32) with one shared
// stimulus stream. A behavioural model predicts, per instance, when each
// accepted operation completes and what its full product is; a negedge
// process compares every output of every instance against it each cycle.
module tb_mul_seq_n;
    localparam int NI = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    logic [NI-1:0] done_v;
    logic [NI-1:0] ready_v;
    logic [NI-1:0] busy_v;
    logic [31:0]   res_hi_v [NI];
    logic [31:0]   res_lo_v [NI];

    int vectors;
    int miscompares;

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One instance per BPC value, all fed from the same inputs.
    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_inst
            mul_seq_n_if #(.WIDTH(32)) bus ();

            assign bus.start = start;
            assign bus.op    = op;
            assign bus.a     = a;
            assign bus.b     = b;
            assign bus.kill  = kill;

            assign done_v[gi]   = bus.done;
            assign ready_v[gi]  = bus.ready;
            assign busy_v[gi]   = bus.busy;
            assign res_hi_v[gi] = bus.result_hi;
            assign res_lo_v[gi] = bus.result_lo;

            mul_seq_n #(.WIDTH(32), .BPC(1 << gi)) dut (
                .clk   (clk),
                .reset (reset),
                .bus   (bus.slave)
            );
        end
    endgenerate

    // Exact product of the operands as interpreted by op, modulo 2^64.
    function automatic logic [63:0] refProduct(input logic [1:0] o,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = (o != 2'b11) ? {{32{x[31]}}, x} : {32'b0, x};
        sy = (o[1] == 1'b0) ? {{32{y[31]}}, y} : {32'b0, y};
        return sx * sy;
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d]: actual 0x%0h, required 0x%0h",
                     name, idx, actual, expected);
        end
    endtask

    // Model state: an accepted op finishes N+1 edges after its start edge,
    // unless killed or reset first.
    longint      cyc;
    bit          checking;
    bit          m_active  [NI];
    longint      m_finish  [NI];
    longint      m_done_at [NI];
    logic [63:0] m_pend    [NI];
    logic [63:0] m_held    [NI];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_active[i]  = 1'b0;
                m_done_at[i] = -10;
                m_held[i]    = '0;
            end else if (m_active[i]) begin
                if (kill) begin
                    m_active[i] = 1'b0;
                end else if (cyc == m_finish[i]) begin
                    m_active[i]  = 1'b0;
                    m_held[i]    = m_pend[i];
                    m_done_at[i] = cyc;
                end
            end else if (start && !(kill && m_done_at[i] == cyc - 1)) begin
                m_active[i] = 1'b1;
                m_finish[i] = cyc + longint'(32 >> i) + 1;
                m_pend[i]   = refProduct(op, a, b);
            end
        end
        if (reset) checking = 1'b1;
    end

    // Compare every instance's outputs with the model each cycle.
    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < NI; i++) begin
                checkOutput("done", i, 64'(done_v[i]), 64'(m_done_at[i] == cyc));
                checkOutput("ready", i, 64'(ready_v[i]), 64'(!m_active[i]));
                checkOutput("busy", i, 64'(busy_v[i]), 64'(m_active[i]));
                checkOutput("result", i, {res_hi_v[i], res_lo_v[i]}, m_held[i]);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the start edge,
    // with the operand inputs scrambled since they need not stay stable.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x,
                                 input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom();
        b     = $urandom();
        op    = 2'($urandom_range(0, 3));
    endtask

    // Counts edges from the start edge to the first done of each instance.
    task automatic measureLatency();
        int lat [NI];
        bit all_seen;
        for (int i = 0; i < NI; i++) lat[i] = -1;
        for (int e = 1; e <= 100; e++) begin
            @(negedge clk);
            all_seen = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (done_v[i] && lat[i] < 0) lat[i] = e;
                if (lat[i] < 0) all_seen = 1'b0;
            end
            if (all_seen) break;
        end
        for (int i = 0; i < NI; i++) begin
            checkOutput("latency", i, 64'(lat[i]), 64'((32 >> i) + 1));
        end
    endtask

    task automatic checkAll(input string name, input logic [63:0] expected);
        for (int i = 0; i < NI; i++) begin
            checkOutput(name, i, {res_hi_v[i], res_lo_v[i]}, expected);
        end
    endtask

    task automatic runOp(input string name, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] expected);
        applyStimulus(o, x, y);
        measureLatency();
        checkAll(name, expected);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Global bound in case a wait loop is ever mis-sequenced.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        int done_count;
        bit settled;

        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        checking    = 1'b0;
        for (int i = 0; i < NI; i++) begin
            m_active[i]  = 1'b0;
            m_finish[i]  = 0;
            m_done_at[i] = -10;
            m_pend[i]    = '0;
            m_held[i]    = '0;
        end
        reset = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;

        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checkOutput("rst_ready", i, 64'(ready_v[i]), 64'd1);
            checkOutput("rst_busy", i, 64'(busy_v[i]), 64'd0);
            checkOutput("rst_done", i, 64'(done_v[i]), 64'd0);
        end
        checkAll("rst_result", 64'h0);
        reset = 1'b0;

        // Pin the reference product with hand-computed values.
        checkOutput("ref_mulhu_7x6", 0, refProduct(2'b11, 32'd7, 32'd6), 64'h2A);
        checkOutput("ref_mulh_m1", 0, refProduct(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'h1);
        checkOutput("ref_mulhu_m1", 0, refProduct(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        checkOutput("ref_mulhsu", 0, refProduct(2'b10, 32'hFFFF_FFFF, 32'h2), 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("ref_mulh_min", 0, refProduct(2'b01, 32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);

        // Directed products, each also checking per-BPC latency.
        runOp("mulhu_7x6", 2'b11, 32'd7, 32'd6, 64'h2A);
        @(negedge clk);
        runOp("mulh_m1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1);
        @(negedge clk);
        runOp("mulhu_m1", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        runOp("mulhsu", 2'b10, 32'hFFFF_FFFF, 32'h2, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        runOp("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        @(negedge clk);
        runOp("mulhu_big", 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080);
        @(negedge clk);

        // Start mid-operation is ignored; start in DONE issues back to back.
        applyStimulus(2'b11, 32'd7, 32'd6);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd3;
        b     = 32'd6;
        @(negedge clk);
        start = 1'b0;
        settled = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (done_v[0]) begin
                settled = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("wait_done", 0, 64'(settled), 64'd1);
        checkAll("ignored_start", 64'h2A);
        runOp("back_to_back", 2'b11, 32'd2, 32'd3, 64'h6);
        @(negedge clk);

        // Kill at edge 10: BPC 1/2 abort silently and keep the old result.
        applyStimulus(2'b11, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        done_count = 0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("kill_ready", i, 64'(ready_v[i]), 64'd1);
            checkOutput("kill_hold", i, {res_hi_v[i], res_lo_v[i]}, 64'h6);
        end
        repeat (40) begin
            @(negedge clk);
            if (done_v[0]) done_count++;
        end
        checkOutput("kill_no_done", 0, 64'(done_count), 64'd0);

        // Reset at edge 10 clears results and drops the operation.
        applyStimulus(2'b11, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkAll("reset_mid", 64'h0);
        for (int i = 0; i < NI; i++) begin
            checkOutput("reset_done", i, 64'(done_v[i]), 64'd0);
        end

        // Random sweep with stray starts and kills mixed in.
        for (int n = 0; n < 1000; n++) begin
            applyStimulus(2'($urandom_range(0, 3)), pickOperand(), pickOperand());
            settled = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (c < 40 && $urandom_range(0, 39) == 0) kill = 1'b1;
                if (c < 40 && $urandom_range(0, 24) == 0) begin
                    start = 1'b1;
                    op    = 2'($urandom_range(0, 3));
                    a     = pickOperand();
                    b     = pickOperand();
                end
                @(negedge clk);
                start = 1'b0;
                kill  = 1'b0;
                a     = $urandom();
                b     = $urandom();
                if (&ready_v) begin
                    settled = 1'b1;
                    break;
                end
            end
            if (!settled) begin
                checkOutput("random_settle", n, 64'(settled), 64'd1);
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
